// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder walks the operands LSB-first with a registered carry.
// WIDTH+1 cycles from start to done; start is ignored while busy, and results stay held until the next done.

module adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fa_sum, fa_cout;

   adder_1bit u_fa (
      .a   (a_q[0]),
      .b   (b_q[0]),
      .cin (carry_q),
      .sum (fa_sum),
      .cout(fa_cout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               // Subtraction is a + ~b + 1; the +1 rides in on the initial carry.
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = {fa_sum, res_q[WIDTH-1:1]};
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // carry_q is still the carry into the MSB here.
               sum_d   = {fa_sum, res_q[WIDTH-1:1]};
               cout_d  = fa_cout;
               ovf_d   = carry_q ^ fa_cout;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed and random 8-bit operations plus an exhaustive 4-bit sweep,
// each compared against an arithmetic reference model.

module tb_serial_adder_ctrl;
   logic       clk;
   logic       rst_n;

   logic       start8, sub8, busy8, done8, cout8, ovf8;
   logic [7:0] a8, b8, sum8;
   logic       start4, sub4, busy4, done4, cout4, ovf4;
   logic [3:0] a4, b4, sum4;

   int checks = 0;
   int errors = 0;
   int prev_sum = 0;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
   );

   serial_adder_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic void model(input int w, input int av, input int bv, input bit sv,
                                 output int s, output bit c, output bit v);
      int m, full, sa, sb, r;
      m    = 1 << w;
      full = sv ? (av + (m - bv)) : (av + bv);
      s    = full % m;
      c    = (full >= m);
      sa   = (av >= m / 2) ? av - m : av;
      sb   = (bv >= m / 2) ? bv - m : bv;
      r    = sv ? (sa - sb) : (sa + sb);
      v    = (r < -(m / 2)) || (r >= m / 2);
   endfunction

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sv, input int inj);
      int s, n;
      bit c, v, seen;
      model(8, av, bv, sv, s, c, v);
      start8 = 1'b1; a8 = av; b8 = bv; sub8 = sv;
      @(posedge clk);
      #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      n = 0; seen = 0;
      while (!seen && n < 12) begin
         @(negedge clk);
         n++;
         if (n == inj) begin
            start8 = 1'b1; a8 = 8'h11;
         end else begin
            start8 = 1'b0;
         end
         if (done8 === 1'b1) begin
            seen = 1;
         end else begin
            chk("busy8_run", busy8, 1);
            chk("sum8_held", sum8, prev_sum);
         end
      end
      chk("lat8", n, 9);
      chk("busy8_at_done", busy8, 0);
      chk("sum8", sum8, s);
      chk("cout8", cout8, c);
      chk("ovf8", ovf8, v);
      prev_sum = s;
   endtask

   task automatic idle8(input int cyc);
      for (int i = 0; i < cyc; i++) begin
         @(negedge clk);
         chk("no_done8", done8, 0);
      end
   endtask

   task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic sv);
      int s, n;
      bit c, v, seen;
      model(4, av, bv, sv, s, c, v);
      start4 = 1'b1; a4 = av; b4 = bv; sub4 = sv;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      n = 0; seen = 0;
      while (!seen && n < 8) begin
         @(negedge clk);
         n++;
         if (done4 === 1'b1) seen = 1;
      end
      chk("lat4", n, 5);
      chk("sum4", sum4, s);
      chk("cout4", cout4, c);
      chk("ovf4", ovf4, v);
   endtask

   initial begin
      rst_n = 1'b0;
      start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
      #12;
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_sum", sum8, 0);
      chk("rst_cout", cout8, 0);
      chk("rst_ovf", ovf8, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle8(2);

      op8(8'h5A, 8'h33, 1'b0, 0);
      idle8(2);
      op8(8'hFF, 8'h01, 1'b0, 0);
      op8(8'h10, 8'h20, 1'b1, 0);
      idle8(1);
      op8(8'h80, 8'h01, 1'b1, 0);
      op8(8'h01, 8'h01, 1'b0, 0);
      idle8(2);
      op8(8'h05, 8'h03, 1'b0, 3);
      idle8(12);

      // Asynchronous reset between clock edges during RUN.
      start8 = 1'b1; a8 = 8'h7E; b8 = 8'h11; sub8 = 1'b0;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy8, 0);
      chk("arst_done", done8, 0);
      chk("arst_sum", sum8, 0);
      chk("arst_cout", cout8, 0);
      chk("arst_ovf", ovf8, 0);
      @(negedge clk);
      rst_n = 1'b1;
      prev_sum = 0;
      idle8(12);
      op8(8'hC3, 8'h5C, 1'b1, 0);

      for (int i = 0; i < 20; i++) begin
         op8(8'($urandom), 8'($urandom), 1'($urandom), 0);
         idle8(int'($urandom_range(0, 2)));
      end

      @(negedge clk);
      for (int s = 0; s < 2; s++)
         for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
               op4(4'(x), 4'(y), 1'(s));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
